// File: rtl/ex_alu_md_ctrl_if.sv
// ex_alu_md_ctrl_if
//  Groups the EX-stage signals exchanged between the pipeline (master) and the
//  ALU-control / multiply-divide sequencer (slave).
//  master drives: EX_valid, EX_flush, EX_alu_op, EX_funct, EX_rs_data, EX_rt_data
//  master reads : EX_alu_select, EX_hilo_rdata, EX_md_busy, EX_stall
interface ex_alu_md_ctrl_if #(
    parameter int DATA_W    = 32,
    parameter int ALU_SEL_W = 4
);
    logic                 EX_valid;
    logic                 EX_flush;
    logic [1:0]           EX_alu_op;
    logic [5:0]           EX_funct;
    logic [DATA_W-1:0]    EX_rs_data;
    logic [DATA_W-1:0]    EX_rt_data;
    logic [ALU_SEL_W-1:0] EX_alu_select;
    logic [DATA_W-1:0]    EX_hilo_rdata;
    logic                 EX_md_busy;
    logic                 EX_stall;

    modport master (
        output EX_valid, EX_flush, EX_alu_op, EX_funct, EX_rs_data, EX_rt_data,
        input  EX_alu_select, EX_hilo_rdata, EX_md_busy, EX_stall
    );

    modport slave (
        input  EX_valid, EX_flush, EX_alu_op, EX_funct, EX_rs_data, EX_rt_data,
        output EX_alu_select, EX_hilo_rdata, EX_md_busy, EX_stall
    );
endinterface

// File: rtl/ex_alu_md_ctrl.sv
// ex_alu_md_ctrl
//  Execute-stage ALU control for the MIPS core with an iterative multiply /
//  divide sequencer owning the HI/LO registers.
//  - Decodes EX_alu_op / EX_funct into a 4-bit ALU select (zero-extended).
//  - MULT/MULTU/DIV/DIVU run one bit per cycle (IDLE -> RUN x DATA_W -> FIX).
//  - MFHI/MFLO read HI/LO combinationally; MTHI/MTLO write them.
//  - EX_stall holds the pipeline while a HI/LO consumer or another mul/div
//    meets a busy sequencer.
// Ports
//  clk  : clock, rising edge
//  rst  : synchronous reset, active-high
//  bus  : ex_alu_md_ctrl_if.slave (EX_valid, EX_flush, EX_alu_op, EX_funct,
//         EX_rs_data, EX_rt_data in; EX_alu_select, EX_hilo_rdata,
//         EX_md_busy, EX_stall out)
module ex_alu_md_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ALU_SEL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    ex_alu_md_ctrl_if.slave     bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_XOR  = 4'b0011;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SLT  = 4'b0111;
    localparam logic [3:0] SEL_NOR  = 4'b1100;
    localparam logic [3:0] SEL_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;       // mul: {partial HI, multiplier/LO}; div: {remainder, quotient}
    logic [DATA_W-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;  // product / quotient must be negated
    logic                neg_rem_q, neg_rem_d;  // remainder takes dividend sign
    logic                div0_q, div0_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic r_type, is_md, is_hilo, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic signed_op;

    assign r_type    = (bus.EX_alu_op == 2'b10);
    assign is_md     = r_type && (bus.EX_funct[5:2] == 4'b0110);
    assign is_hilo   = r_type && (bus.EX_funct[5:2] == 4'b0100);
    assign is_mfhi   = r_type && (bus.EX_funct == 6'b010000);
    assign is_mthi   = r_type && (bus.EX_funct == 6'b010001);
    assign is_mflo   = r_type && (bus.EX_funct == 6'b010010);
    assign is_mtlo   = r_type && (bus.EX_funct == 6'b010011);
    // MULT/DIV have funct[0]=0, MULTU/DIVU have funct[0]=1
    assign signed_op = ~bus.EX_funct[0];

    logic [3:0] sel4;
    always_comb begin
        sel4 = SEL_ADD;
        case (bus.EX_alu_op)
            2'b00: sel4 = SEL_ADD;
            2'b01: sel4 = SEL_SUB;
            2'b11: sel4 = SEL_OR;
            default: begin
                case (bus.EX_funct)
                    6'b100000, 6'b100001: sel4 = SEL_ADD;
                    6'b100010, 6'b100011: sel4 = SEL_SUB;
                    6'b100100:            sel4 = SEL_AND;
                    6'b100101:            sel4 = SEL_OR;
                    6'b100110:            sel4 = SEL_XOR;
                    6'b100111:            sel4 = SEL_NOR;
                    6'b101010:            sel4 = SEL_SLT;
                    6'b101011:            sel4 = SEL_SLTU;
                    default:              sel4 = SEL_ADD;
                endcase
            end
        endcase
    end

    assign bus.EX_alu_select = ALU_SEL_W'(sel4);

    // ------------------------------------------------------------------
    // Hazard / handshake
    // ------------------------------------------------------------------
    logic stall;
    logic issue_ok;
    logic accept;

    assign stall    = bus.EX_valid && !bus.EX_flush && busy_q && (is_md || is_hilo);
    assign issue_ok = bus.EX_valid && !bus.EX_flush && !stall;
    assign accept   = (state_q == ST_IDLE) && issue_ok && is_md;

    assign bus.EX_stall      = stall;
    assign bus.EX_md_busy    = busy_q;
    // Reads see the register value of this cycle; a FIX write lands at the edge
    // and is not forwarded (a consumer is stalled during FIX anyway).
    assign bus.EX_hilo_rdata = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

    // ------------------------------------------------------------------
    // Operand magnitudes at accept
    // ------------------------------------------------------------------
    logic              rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_mag, rt_mag;

    assign rs_neg = signed_op && bus.EX_rs_data[DATA_W-1];
    assign rt_neg = signed_op && bus.EX_rt_data[DATA_W-1];
    assign rs_mag = rs_neg ? (-bus.EX_rs_data) : bus.EX_rs_data;
    assign rt_mag = rt_neg ? (-bus.EX_rt_data) : bus.EX_rt_data;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Shift-add multiply: add multiplicand into the upper half when the LSB of
    // the multiplier is set, then shift the whole accumulator right by one.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // Restoring divide: the partial remainder after the left shift needs one
    // extra bit, taken as acc[2W-1:W-1]; a borrow out of the trial subtract
    // means the divisor did not fit and the shifted value is kept.
    logic [DATA_W:0]     div_rem;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_next;

    assign div_rem  = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_diff = div_rem - {1'b0, opnd_q};
    assign div_next = div_diff[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                       : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    assign prod_fix = neg_res_q ? (-acc_q) : acc_q;
    assign quot_fix = div0_q ? {DATA_W{1'b1}}
                             : (neg_res_q ? (-acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0]);
    // With a zero divisor the remainder holds |rs|, so re-signing it yields rs.
    assign rem_fix  = neg_rem_q ? (-acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (issue_ok && is_mthi) hi_d = bus.EX_rs_data;
        if (issue_ok && is_mtlo) lo_d = bus.EX_rs_data;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_div_d  = bus.EX_funct[1];
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    div0_d    = (bus.EX_rt_data == '0);
                    // mul: multiplier sits in the low half; div: dividend does
                    acc_d     = {{DATA_W{1'b0}}, bus.EX_funct[1] ? rs_mag : rt_mag};
                    opnd_d    = bus.EX_funct[1] ? rt_mag : rs_mag;
                    count_d   = CNT_W'(DATA_W - 1);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (count_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush abandons the running operation without touching HI/LO.
        if (bus.EX_flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_alu_md_ctrl.sv
module tb_ex_alu_md_ctrl;
    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_alu_md_ctrl_if #(.DATA_W(W), .ALU_SEL_W(4)) bus ();

    ex_alu_md_ctrl #(.DATA_W(W), .ALU_SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   fn;
        logic [3:0]   sel;
        bit           chk_rd;
        logic [W-1:0] rd;
    } exp_t;

    exp_t         sb_q[$];
    int           n_total = 0;
    int           n_pass  = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference ALU select table
    function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (fn)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24:        return 4'b0000;
            6'h25:        return 4'b0001;
            6'h26:        return 4'b0011;
            6'h27:        return 4'b1100;
            6'h2A:        return 4'b0111;
            6'h2B:        return 4'b1111;
            default:      return 4'b0010;
        endcase
    endfunction

    // Architectural effect of an instruction on HI/LO, in plain arithmetic
    task automatic ref_exec(input logic [1:0] op, input logic [5:0] fn,
                            input logic [W-1:0] rs, input logic [W-1:0] rt);
        longint      sp;
        logic [63:0] up;
        int          a, b;
        if (op != 2'b10) return;
        a = $signed(rs);
        b = $signed(rt);
        case (fn)
            F_MULT: begin
                sp = longint'(a) * longint'(b);
                up = sp;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            F_MULTU: begin
                up = 64'(rs) * 64'(rt);
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            F_DIV: begin
                if (b == 0) begin
                    m_hi = rs;
                    m_lo = '1;
                end else if (rs == 32'h8000_0000 && b == -1) begin
                    m_lo = 32'h8000_0000;
                    m_hi = '0;
                end else begin
                    m_lo = 32'(a / b);
                    m_hi = 32'(a % b);
                end
            end
            F_DIVU: begin
                if (rt == '0) begin
                    m_hi = rs;
                    m_lo = '1;
                end else begin
                    m_lo = rs / rt;
                    m_hi = rs % rt;
                end
            end
            F_MTHI: m_hi = rs;
            F_MTLO: m_lo = rs;
            default: ;
        endcase
    endtask

    // Drive one instruction, queue its expectation, hold it until it leaves EX.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] rs, input logic [W-1:0] rt,
                         input bit commit, output int stalls, output logic busy_rel);
        exp_t e;
        bus.EX_valid   = 1'b1;
        bus.EX_flush   = 1'b0;
        bus.EX_alu_op  = op;
        bus.EX_funct   = fn;
        bus.EX_rs_data = rs;
        bus.EX_rt_data = rt;
        e.op     = op;
        e.fn     = fn;
        e.sel    = ref_sel(op, fn);
        e.chk_rd = (op == 2'b10) && (fn == F_MFHI || fn == F_MFLO);
        e.rd     = (fn == F_MFHI) ? m_hi : m_lo;
        sb_q.push_back(e);
        if (commit) ref_exec(op, fn, rs, rt);
        stalls   = 0;
        busy_rel = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus.EX_stall) begin
                busy_rel = bus.EX_md_busy;
                break;
            end
            stalls++;
            if (stalls > 100) begin
                n_total++;
                $display("FAIL stall_timeout: got stall for %0d cycles expected release", stalls);
                sb_q.delete(sb_q.size() - 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.EX_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(-$urandom_range(1, 100));
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop and compare whenever an instruction leaves EX
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.EX_valid && !bus.EX_flush && !bus.EX_stall) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got op=%b fn=%h expected nothing queued",
                             bus.EX_alu_op, bus.EX_funct);
                end else begin
                    e = sb_q.pop_front();
                    check("alu_select", W'(bus.EX_alu_select), W'(e.sel));
                    if (e.chk_rd) check("hilo_rdata", bus.EX_hilo_rdata, e.rd);
                    $display("txn op=%b fn=%h sel=%h rdata=%h", e.op, e.fn, bus.EX_alu_select,
                             bus.EX_hilo_rdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        int           st;
        logic         br;
        logic [5:0]   sweep_fn[13];
        logic [5:0]   rand_fn[18];
        logic [W-1:0] a, b;

        sweep_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2A, 6'h2B, 6'h00, F_MFHI, F_MFLO};
        rand_fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F,
                     F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'h00};

        rst            = 1'b1;
        bus.EX_valid   = 1'b0;
        bus.EX_flush   = 1'b0;
        bus.EX_alu_op  = 2'b00;
        bus.EX_funct   = 6'h00;
        bus.EX_rs_data = '0;
        bus.EX_rt_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_busy", W'(bus.EX_md_busy), W'(1'b0));
        check("reset_stall", W'(bus.EX_stall), W'(1'b0));
        check("reset_rdata", bus.EX_hilo_rdata, '0);
        bus.EX_alu_op = 2'b10;
        bus.EX_funct  = F_MFLO;
        @(negedge clk);
        check("reset_lo", bus.EX_hilo_rdata, '0);
        @(posedge clk);
        #1;

        // Decode sweep
        issue(2'b00, 6'($urandom), $urandom, $urandom, 1'b1, st, br);
        issue(2'b01, 6'($urandom), $urandom, $urandom, 1'b1, st, br);
        issue(2'b11, 6'($urandom), $urandom, $urandom, 1'b1, st, br);
        foreach (sweep_fn[i]) issue(2'b10, sweep_fn[i], $urandom, $urandom, 1'b1, st, br);

        // Directed mul/div vectors
        issue(2'b10, F_MULT,  32'hFFFF_FFFD, 32'd7,        1'b1, st, br);
        issue(2'b10, F_MFHI,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_MFLO,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, st, br);
        issue(2'b10, F_MFHI,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_MFLO,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, st, br);
        issue(2'b10, F_MFLO,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_MFHI,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_DIVU,  32'd7, 32'd0,                1'b1, st, br);
        issue(2'b10, F_MFHI,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_MFLO,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, st, br);
        issue(2'b10, F_MFLO,  '0, '0, 1'b1, st, br);
        issue(2'b10, F_MFHI,  '0, '0, 1'b1, st, br);

        // MFLO right behind a MULT: stall length and busy/stall release together
        issue(2'b10, F_MULT, $urandom, $urandom, 1'b1, st, br);
        issue(2'b10, F_MFLO, '0, '0, 1'b1, st, br);
        check("stall_cycles", W'(st), W'(33));
        check("busy_at_release", W'(br), W'(1'b0));

        // Flush at RUN count 10 leaves HI/LO alone; next MULT accepted at once
        issue(2'b10, F_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, st, br);
        repeat (21) @(posedge clk);
        #1;
        bus.EX_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.EX_flush = 1'b0;
        @(negedge clk);
        check("flush_busy", W'(bus.EX_md_busy), W'(1'b0));
        @(posedge clk);
        #1;
        issue(2'b10, F_MFHI, '0, '0, 1'b1, st, br);
        issue(2'b10, F_MFLO, '0, '0, 1'b1, st, br);
        issue(2'b10, F_MULTU, 32'd1000, 32'd3000, 1'b1, st, br);
        @(negedge clk);
        check("accept_after_flush", W'(bus.EX_md_busy), W'(1'b1));
        @(posedge clk);
        #1;
        issue(2'b10, F_MFLO, '0, '0, 1'b1, st, br);

        // MTHI then MFHI
        issue(2'b10, F_MTHI, 32'h0000_1234, '0, 1'b1, st, br);
        issue(2'b10, F_MFHI, '0, '0, 1'b1, st, br);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            a = rand_data();
            b = rand_data();
            if ($urandom_range(0, 3) == 0)
                issue(2'($urandom_range(0, 3)), 6'($urandom), a, b, 1'b1, st, br);
            else
                issue(2'b10, rand_fn[$urandom_range(0, 17)], a, b, 1'b1, st, br);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
        end

        // Reset during RUN discards the operation and clears HI/LO
        issue(2'b10, F_MTLO, 32'hCAFE_0001, '0, 1'b1, st, br);
        issue(2'b10, F_MULT, 32'd11, 32'd13, 1'b0, st, br);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check("rst_run_busy", W'(bus.EX_md_busy), W'(1'b0));
        @(posedge clk);
        #1;
        issue(2'b10, F_MFHI, '0, '0, 1'b1, st, br);
        issue(2'b10, F_MFLO, '0, '0, 1'b1, st, br);

        repeat (3) @(posedge clk);
        check("scoreboard_drain", W'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
